// File: rtl/eth_tx_framer_pkg.sv
// Shared types and constants for the TX length framer.
package eth_tx_framer_pkg;

    localparam int unsigned ETH_MIN_PACKET_LENGTH = 64;
    localparam int unsigned ETH_MAX_PACKET_LENGTH = 1522;
    localparam int unsigned DEF_LENGTH_WIDTH      = $clog2(ETH_MAX_PACKET_LENGTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One output beat as carried through the skid buffer.
    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

endpackage

// File: rtl/eth_tx_length_framer_if.sv
// Descriptor, source byte stream and MAC-side AXIS bundle for the TX length framer.
interface eth_tx_length_framer_if
    import eth_tx_framer_pkg::*;
#(
    parameter int unsigned LENGTH_WIDTH = DEF_LENGTH_WIDTH
);
    logic [LENGTH_WIDTH-1:0] s_len_tdata;
    logic                    s_len_tvalid;
    logic                    s_len_tready;
    logic [7:0]              s_axis_tdata;
    logic                    s_axis_tvalid;
    logic                    s_axis_tready;
    logic                    s_axis_tlast;
    logic [7:0]              m_axis_tdata;
    logic                    m_axis_tvalid;
    logic                    m_axis_tready;
    logic                    m_axis_tlast;
    logic                    m_axis_tuser;

    // Framer side.
    modport slave (
        input  s_len_tdata, s_len_tvalid,
        output s_len_tready,
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        input  m_axis_tready
    );

    // Environment side (FIFO source and MAC sink).
    modport master (
        output s_len_tdata, s_len_tvalid,
        input  s_len_tready,
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        output m_axis_tready
    );

endinterface

// File: rtl/eth_tx_framer_skid.sv
// Two-entry AXIS register slice; in_ready and all outputs come straight from flops.
module eth_tx_framer_skid
    import eth_tx_framer_pkg::*;
(
    input  logic  tx_clk,
    input  logic  tx_rst,
    input  logic  in_valid,
    output logic  in_ready,
    input  beat_t in_beat,
    output logic  out_valid,
    input  logic  out_ready,
    output beat_t out_beat
);

    beat_t      head;
    beat_t      tail;
    logic [1:0] count;
    logic       push;
    logic       pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_beat  = head;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Head is only replaced on pop or when empty, so it holds steady under backpressure.
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= in_beat;
                    else               tail <= in_beat;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Only reachable with one entry held: the new beat becomes head.
                    head <= in_beat;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/eth_tx_length_framer.sv
// TX length framer: emits one AXIS frame of exactly L bytes per length descriptor,
// generating tlast from L and checking the source tlast for short/overrun frames.
// Optional statistics counters are built when ETH_TX_LEN_FRAMER_STATS_EN is defined.
module eth_tx_length_framer
    import eth_tx_framer_pkg::*;
#(
    parameter int unsigned LENGTH_WIDTH = DEF_LENGTH_WIDTH,
    parameter int unsigned MAX_LEN      = ETH_MAX_PACKET_LENGTH
) (
    input  logic                  tx_clk,
    input  logic                  tx_rst,
    eth_tx_length_framer_if.slave bus,
    output logic                  err_len_invalid,
    output logic                  err_short,
    output logic                  err_overrun
`ifdef ETH_TX_LEN_FRAMER_STATS_EN
    ,
    output logic [31:0]           stat_frames,
    output logic [31:0]           stat_bytes,
    output logic [31:0]           stat_errors
`endif
);

    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_DATA  = 2'(DATA);
    localparam logic [1:0] S_DRAIN = 2'(DRAIN);

    logic [1:0]              state;
    logic [1:0]              state_nxt;
    logic [LENGTH_WIDTH-1:0] remain;
    logic [LENGTH_WIDTH-1:0] remain_nxt;
    logic                    len_rdy;
    logic                    data_rdy;
    logic                    drain_rdy;
    logic                    len_legal_c;
    logic                    len_fire_c;
    logic                    data_fire_c;
    logic                    drain_fire_c;
    logic                    push_c;
    beat_t                   push_beat_c;
    logic                    err_len_c;
    logic                    err_short_c;
    logic                    err_over_c;
    logic                    skid_in_ready;
    logic                    skid_out_valid;
    beat_t                   skid_out_beat;

    assign len_legal_c  = (bus.s_len_tdata != '0) && (32'(bus.s_len_tdata) <= MAX_LEN);
    assign len_fire_c   = bus.s_len_tvalid & len_rdy;
    assign data_fire_c  = bus.s_axis_tvalid & data_rdy & skid_in_ready;
    assign drain_fire_c = bus.s_axis_tvalid & drain_rdy;

    // Ready strobes are one-hot copies of the state, cleared during reset.
    assign bus.s_len_tready  = len_rdy;
    assign bus.s_axis_tready = (data_rdy & skid_in_ready) | drain_rdy;

    // State, remaining count and ready flops.
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            state     <= S_IDLE;
            remain    <= '0;
            len_rdy   <= 1'b0;
            data_rdy  <= 1'b0;
            drain_rdy <= 1'b0;
        end else begin
            state     <= state_nxt;
            remain    <= remain_nxt;
            len_rdy   <= (state_nxt == S_IDLE);
            data_rdy  <= (state_nxt == S_DATA);
            drain_rdy <= (state_nxt == S_DRAIN);
        end
    end

    // Next state, beat formation and error detection.
    always_comb begin
        state_nxt   = state;
        remain_nxt  = remain;
        push_c      = 1'b0;
        push_beat_c = '0;
        err_len_c   = 1'b0;
        err_short_c = 1'b0;
        err_over_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (len_fire_c) begin
                    if (len_legal_c) begin
                        remain_nxt = bus.s_len_tdata;
                        state_nxt  = S_DATA;
                    end else begin
                        err_len_c = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (data_fire_c) begin
                    push_c           = 1'b1;
                    push_beat_c.data = bus.s_axis_tdata;
                    remain_nxt       = remain - LENGTH_WIDTH'(1);
                    if (remain == LENGTH_WIDTH'(1)) begin
                        push_beat_c.last = 1'b1;
                        if (bus.s_axis_tlast) begin
                            state_nxt = S_IDLE;
                        end else begin
                            err_over_c = 1'b1;
                            state_nxt  = S_DRAIN;
                        end
                    end else if (bus.s_axis_tlast) begin
                        // Source ended early: close the frame and mark it bad for the MAC.
                        push_beat_c.last = 1'b1;
                        push_beat_c.user = 1'b1;
                        err_short_c      = 1'b1;
                        remain_nxt       = '0;
                        state_nxt        = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_fire_c && bus.s_axis_tlast) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                remain_nxt = '0;
                state_nxt  = S_IDLE;
            end
        endcase
    end

    // Error pulses, one cycle each.
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            err_len_invalid <= 1'b0;
            err_short       <= 1'b0;
            err_overrun     <= 1'b0;
        end else begin
            err_len_invalid <= err_len_c;
            err_short       <= err_short_c;
            err_overrun     <= err_over_c;
        end
    end

    eth_tx_framer_skid u_skid (
        .tx_clk    (tx_clk),
        .tx_rst    (tx_rst),
        .in_valid  (push_c),
        .in_ready  (skid_in_ready),
        .in_beat   (push_beat_c),
        .out_valid (skid_out_valid),
        .out_ready (bus.m_axis_tready),
        .out_beat  (skid_out_beat)
    );

    assign bus.m_axis_tvalid = skid_out_valid;
    assign bus.m_axis_tdata  = skid_out_beat.data;
    assign bus.m_axis_tlast  = skid_out_beat.last;
    assign bus.m_axis_tuser  = skid_out_beat.user;

`ifdef ETH_TX_LEN_FRAMER_STATS_EN
    logic m_fire;
    assign m_fire = bus.m_axis_tvalid & bus.m_axis_tready;

    // Wrapping frame/byte/error counters; error sources are mutually exclusive per cycle.
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            stat_frames <= 32'd0;
            stat_bytes  <= 32'd0;
            stat_errors <= 32'd0;
        end else begin
            if (m_fire) stat_bytes <= stat_bytes + 32'd1;
            if (m_fire && bus.m_axis_tlast && !bus.m_axis_tuser) stat_frames <= stat_frames + 32'd1;
            if (err_len_invalid || err_short || err_overrun) stat_errors <= stat_errors + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_eth_tx_length_framer.sv
// Bench for eth_tx_length_framer: directed frames plus random frames against a frame-level model.
module tb_eth_tx_length_framer;
    import eth_tx_framer_pkg::*;

    localparam int unsigned LW      = 11;
    localparam int unsigned MAX_LEN = 1522;
    localparam int          TIMEOUT = 4000;

    logic tx_clk;
    logic tx_rst;
    logic err_len_invalid;
    logic err_short;
    logic err_overrun;
`ifdef ETH_TX_LEN_FRAMER_STATS_EN
    logic [31:0] stat_frames;
    logic [31:0] stat_bytes;
    logic [31:0] stat_errors;
`endif

    eth_tx_length_framer_if #(.LENGTH_WIDTH(LW)) bus ();

    eth_tx_length_framer #(.LENGTH_WIDTH(LW), .MAX_LEN(MAX_LEN)) dut (
        .tx_clk          (tx_clk),
        .tx_rst          (tx_rst),
        .bus             (bus),
        .err_len_invalid (err_len_invalid),
        .err_short       (err_short),
        .err_overrun     (err_overrun)
`ifdef ETH_TX_LEN_FRAMER_STATS_EN
        ,
        .stat_frames     (stat_frames),
        .stat_bytes      (stat_bytes),
        .stat_errors     (stat_errors)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int len_acc_cyc = 0;
    int mon_len = 0, mon_short = 0, mon_over = 0;
    int exp_len = 0, exp_short = 0, exp_over = 0;
    bit hung       = 1'b0;
    bit rand_ready = 1'b0;
    bit prev_stall = 1'b0;
    logic [9:0] prev_beat;
    logic [9:0] mbeat;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    logic [7:0] byte_q[$];
    int         dacc_q[$];
    int         beat_cyc_q[$];

    assign mbeat = {bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser};

    initial begin
        tx_clk = 1'b0;
        forever #5 tx_clk = ~tx_clk;
    end

    // MAC ready: always 1, or a coin flip per cycle when rand_ready is set.
    initial begin
        forever begin
            @(posedge tx_clk);
            #1;
            bus.m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observe handshakes, collect output beats and error pulses, check stall stability.
    always @(negedge tx_clk) begin
        if (tx_rst) begin
            prev_stall = 1'b0;
        end else begin
            cyc++;
            chk("ready_exclusive", 32'(bus.s_len_tready & bus.s_axis_tready), 32'd0);
            if (prev_stall) begin
                chk("stall_valid_held", 32'(bus.m_axis_tvalid), 32'd1);
                chk("stall_beat_held", 32'(mbeat), 32'(prev_beat));
            end
            if (bus.s_len_tvalid && bus.s_len_tready) len_acc_cyc = cyc;
            if (bus.s_axis_tvalid && bus.s_axis_tready) dacc_q.push_back(cyc);
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                got_q.push_back(mbeat);
                beat_cyc_q.push_back(cyc);
            end
            if (err_len_invalid) mon_len++;
            if (err_short)       mon_short++;
            if (err_overrun)     mon_over++;
            prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
            prev_beat  = mbeat;
        end
    end

    task automatic send_desc(input int unsigned len);
        int  t = 0;
        bit  acc = 1'b0;
        if (hung) return;
        bus.s_len_tdata  = LW'(len);
        bus.s_len_tvalid = 1'b1;
        while (!acc && t <= TIMEOUT) begin
            @(negedge tx_clk);
            if (bus.s_len_tready) acc = 1'b1;
            else t++;
        end
        if (!acc) begin
            hung = 1'b1;
            chk("desc_accept", 32'(acc), 32'd1);
        end
        @(posedge tx_clk);
        #1;
        bus.s_len_tvalid = 1'b0;
    endtask

    // Sends n bytes, tlast on byte tlast_pos (0 = none), with random idle gaps.
    task automatic send_bytes(input int n, input int tlast_pos, input int gap_pct);
        for (int i = 1; i <= n; i++) begin
            logic [7:0] d;
            int  t;
            bit  acc;
            if (hung) break;
            d = 8'($urandom);
            while (gap_pct != 0 && $urandom_range(0, 99) < gap_pct) begin
                bus.s_axis_tvalid = 1'b0;
                @(posedge tx_clk);
                #1;
            end
            bus.s_axis_tdata  = d;
            bus.s_axis_tlast  = (i == tlast_pos);
            bus.s_axis_tvalid = 1'b1;
            t   = 0;
            acc = 1'b0;
            while (!acc && t <= TIMEOUT) begin
                @(negedge tx_clk);
                if (bus.s_axis_tready) acc = 1'b1;
                else t++;
            end
            if (!acc) begin
                hung = 1'b1;
                chk("byte_accept", 32'(acc), 32'd1);
            end
            byte_q.push_back(d);
            @(posedge tx_clk);
            #1;
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    // Frame-level model: output is min(L, k) source bytes; tlast on the final one,
    // tuser when the source ended before L; bytes beyond L are dropped.
    task automatic model(input int unsigned len, input int unsigned k);
        int unsigned nout = (k < len) ? k : len;
        for (int unsigned i = 0; i < nout; i++) begin
            exp_q.push_back({byte_q[i], 1'(i == nout - 1), 1'((i == nout - 1) && (k < len))});
        end
        if (k < len)      exp_short++;
        else if (k > len) exp_over++;
    endtask

    task automatic check_output();
        int t = 0;
        while (got_q.size() < exp_q.size() && t < TIMEOUT) begin
            @(negedge tx_clk);
            t++;
        end
        repeat (4) @(negedge tx_clk);
        chk("beat_count", 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() != 0 && exp_q.size() != 0) begin
            chk("beat_data_last_user", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
        got_q.delete();
        exp_q.delete();
        chk("err_len_invalid_count", 32'(mon_len), 32'(exp_len));
        chk("err_short_count", 32'(mon_short), 32'(exp_short));
        chk("err_overrun_count", 32'(mon_over), 32'(exp_over));
        @(posedge tx_clk);
        #1;
    endtask

    task automatic run_frame(input int unsigned len, input int unsigned k, input int gap_pct);
        bit legal = (len >= 1) && (len <= MAX_LEN);
        byte_q.delete();
        send_desc(len);
        if (!legal) begin
            exp_len++;
            chk("no_data_after_bad_len", 32'(bus.s_axis_tready), 32'd0);
        end else begin
            send_bytes(int'(k), int'(k), gap_pct);
            model(len, k);
        end
        check_output();
    endtask

    initial begin
        tx_rst            = 1'b1;
        bus.s_len_tdata   = '0;
        bus.s_len_tvalid  = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.m_axis_tready = 1'b1;

        // Reset state.
        repeat (3) @(negedge tx_clk);
        chk("rst_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        chk("rst_s_axis_tready", 32'(bus.s_axis_tready), 32'd0);
        chk("rst_s_len_tready", 32'(bus.s_len_tready), 32'd0);
        chk("rst_errs", 32'({err_len_invalid, err_short, err_overrun}), 32'd0);
        @(posedge tx_clk);
        #1;
        tx_rst = 1'b0;
        repeat (2) @(posedge tx_clk);
        #1;
        chk("idle_s_len_tready", 32'(bus.s_len_tready), 32'd1);

        // Good 64-byte frame at full rate, with latency checks.
        dacc_q.delete();
        beat_cyc_q.delete();
        run_frame(64, 64, 0);
        chk("l64_beats_logged", 32'(beat_cyc_q.size()), 32'd64);
        if (beat_cyc_q.size() == 64 && dacc_q.size() != 0) begin
            chk("l64_back_to_back", 32'(beat_cyc_q[63] - beat_cyc_q[0]), 32'd63);
            chk("first_data_after_desc", 32'(dacc_q[0] - len_acc_cyc), 32'd1);
            chk("byte_to_mac_latency", 32'(beat_cyc_q[0] - dacc_q[0]), 32'd1);
        end

        // Illegal lengths, each followed by a good frame; also both edges of the legal range.
        run_frame(0, 0, 0);
        run_frame(60, 60, 0);
        run_frame(1600, 0, 0);
        run_frame(60, 60, 0);
        run_frame(MAX_LEN + 1, 0, 0);
        run_frame(1, 1, 0);

        // Short frame: source ends at byte 40 of 100.
        run_frame(100, 40, 0);
        // Overrun: 15 source bytes against L=10.
        run_frame(10, 15, 0);

        // Maximum frame under random MAC backpressure.
        rand_ready = 1'b1;
        run_frame(MAX_LEN, MAX_LEN, 0);

        // Random frames: random lengths, source end points, gaps and backpressure.
        for (int f = 0; f < 25; f++) begin
            int unsigned len;
            int unsigned k;
            int unsigned sel;
            sel = $urandom_range(0, 9);
            if (sel == 0)      len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 2047);
            else if (sel == 1) len = $urandom_range(1200, MAX_LEN);
            else               len = $urandom_range(1, 80);
            sel = $urandom_range(0, 2);
            if (sel == 0 && len > 1) k = $urandom_range(1, len - 1);
            else if (sel == 1)       k = len + $urandom_range(1, 6);
            else                     k = len;
            run_frame(len, k, int'($urandom_range(0, 30)));
        end
        rand_ready = 1'b0;
        repeat (2) @(posedge tx_clk);
        #1;

        // Async reset in the middle of a 64-byte frame.
        byte_q.delete();
        send_desc(64);
        send_bytes(30, 0, 0);
        chk("valid_before_rst", 32'(bus.m_axis_tvalid), 32'd1);
        tx_rst = 1'b1;
        #1;
        chk("rst_drops_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
`ifdef ETH_TX_LEN_FRAMER_STATS_EN
        chk("rst_stat_frames", stat_frames, 32'd0);
        chk("rst_stat_bytes", stat_bytes, 32'd0);
        chk("rst_stat_errors", stat_errors, 32'd0);
`endif
        repeat (3) @(posedge tx_clk);
        #1;
        got_q.delete();
        byte_q.delete();
        tx_rst = 1'b0;
        repeat (2) @(posedge tx_clk);
        #1;
        chk("post_rst_s_len_tready", 32'(bus.s_len_tready), 32'd1);
        run_frame(64, 64, 0);
`ifdef ETH_TX_LEN_FRAMER_STATS_EN
        chk("stat_frames", stat_frames, 32'd1);
        chk("stat_bytes", stat_bytes, 32'd64);
        chk("stat_errors", stat_errors, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
